// File: rtl/arc4_pkg.sv
// rtl/arc4_pkg.sv - shared types and constants for the RC4 key-scheduling block
package arc4_pkg;

  localparam int S_DEPTH = 256;

  typedef enum logic [2:0] {
    IDLE,
    INIT_WR,
    RD_I,
    WAIT_I,
    RD_J,
    WAIT_J,
    WR_J,
    WR_I
  } ksa_state_t;

endpackage

// File: rtl/ksa_gen_if.sv
// rtl/ksa_gen_if.sv - start handshake, key and S-memory port of the key scheduler
interface ksa_gen_if #(
  parameter int KEY_BYTES = 3
);

  logic                   en;
  logic                   rdy;
  logic [8*KEY_BYTES-1:0] key;
  logic [7:0]             addr;
  logic [7:0]             rddata;
  logic [7:0]             wrdata;
  logic                   wren;

  modport master (
    input  en, key, rddata,
    output rdy, addr, wrdata, wren
  );

  modport slave (
    output en, key, rddata,
    input  rdy, addr, wrdata, wren
  );

endinterface

// File: rtl/ksa_keysel.sv
// rtl/ksa_keysel.sv - captured key and the byte selected for the current i
module ksa_keysel #(
  parameter int KEY_BYTES = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   load,
  input  logic                   adv,
  input  logic [8*KEY_BYTES-1:0] key,
  output logic [7:0]             key_byte
);

  localparam int IW = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;

  logic [8*KEY_BYTES-1:0] key_q;
  logic [IW-1:0]          idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_q <= '0;
      idx   <= '0;
    end else if (load) begin
      key_q <= key;
      idx   <= '0;
    end else if (adv) begin
      idx <= (idx == IW'(KEY_BYTES - 1)) ? '0 : idx + 1'b1;
    end
  end

  // byte 0 is the most significant byte of the key
  always_comb begin
    key_byte = '0;
    for (int n = 0; n < KEY_BYTES; n++) begin
      if (idx == IW'(n)) key_byte = key_q[8*(KEY_BYTES-1-n) +: 8];
    end
  end

endmodule

// File: rtl/ksa_gen.sv
// rtl/ksa_gen.sv - RC4 key-scheduling sequencer driving an external 256-byte S memory
module ksa_gen
  import arc4_pkg::*;
#(
  parameter int KEY_BYTES = 3,
  parameter int RD_LAT    = 1,
  parameter int DO_INIT   = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  ksa_gen_if.master  bus
);

  localparam logic [1:0] WAIT_LAST = 2'(RD_LAT - 1);
  localparam logic [7:0] I_PRELAST = 8'(S_DEPTH - 2);

  ksa_state_t state;
  logic [7:0] i, j, si, sj;
  logic       i_last;
  logic [1:0] wcnt;
  logic [7:0] key_byte;
  logic [7:0] j_next;
  logic       accept;
  logic       adv;

  assign accept = (state == IDLE) && bus.en;
  assign adv    = (state == WR_I) && !i_last;
  assign j_next = j + bus.rddata + key_byte;

  ksa_keysel #(.KEY_BYTES(KEY_BYTES)) u_keysel (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (accept),
    .adv      (adv),
    .key      (bus.key),
    .key_byte (key_byte)
  );

  // outputs are registered alongside the state, so each transition sets up the next cycle's bus
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      bus.rdy    <= 1'b1;
      bus.wren   <= 1'b0;
      bus.addr   <= '0;
      bus.wrdata <= '0;
      i          <= '0;
      j          <= '0;
      si         <= '0;
      sj         <= '0;
      i_last     <= 1'b0;
      wcnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.en) begin
            bus.rdy    <= 1'b0;
            bus.addr   <= '0;
            bus.wrdata <= '0;
            i          <= '0;
            j          <= '0;
            i_last     <= 1'b0;
            if (DO_INIT != 0) begin
              state    <= INIT_WR;
              bus.wren <= 1'b1;
            end else begin
              state    <= RD_I;
              bus.wren <= 1'b0;
            end
          end
        end
        INIT_WR: begin
          if (i_last) begin
            state    <= RD_I;
            i        <= '0;
            i_last   <= 1'b0;
            bus.addr <= '0;
            bus.wren <= 1'b0;
          end else begin
            i          <= i + 8'd1;
            i_last     <= (i == I_PRELAST);
            bus.addr   <= i + 8'd1;
            bus.wrdata <= i + 8'd1;
          end
        end
        RD_I: begin
          state <= WAIT_I;
          wcnt  <= '0;
        end
        WAIT_I: begin
          if (wcnt == WAIT_LAST) begin
            si       <= bus.rddata;
            j        <= j_next;
            bus.addr <= j_next;
            state    <= RD_J;
          end else begin
            wcnt <= wcnt + 2'd1;
          end
        end
        RD_J: begin
          state <= WAIT_J;
          wcnt  <= '0;
        end
        WAIT_J: begin
          if (wcnt == WAIT_LAST) begin
            sj         <= bus.rddata;
            bus.wrdata <= si;
            bus.wren   <= 1'b1;
            state      <= WR_J;
          end else begin
            wcnt <= wcnt + 2'd1;
          end
        end
        WR_J: begin
          bus.addr   <= i;
          bus.wrdata <= sj;
          state      <= WR_I;
        end
        WR_I: begin
          bus.wren <= 1'b0;
          if (i_last) begin
            state    <= IDLE;
            bus.rdy  <= 1'b1;
            bus.addr <= '0;
            i_last   <= 1'b0;
          end else begin
            i        <= i + 8'd1;
            i_last   <= (i == I_PRELAST);
            bus.addr <= i + 8'd1;
            state    <= RD_I;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ksa_gen.sv
// tb/tb_ksa_gen.sv - three parameterisations of ksa_gen against a plain RC4 KSA model
module tb_ksa_gen;
  import arc4_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst_n;
  logic [2:0]           en_v, rdy_v, wren_v, preload_v;
  logic [2:0][127:0]    key_v;
  logic [2:0][7:0]      addr_v, wrdata_v;
  logic [7:0]           mem  [3][256];
  logic [7:0]           pipe [3][3];

  function automatic int kb_of(input int g);  return (g == 1) ? 5 : 3; endfunction
  function automatic int ini_of(input int g); return (g == 2) ? 0 : 1; endfunction

  for (genvar g = 0; g < 3; g++) begin : cfg
    localparam int KB  = (g == 1) ? 5 : 3;
    localparam int LAT = (g == 0) ? 1 : ((g == 1) ? 2 : 3);
    localparam int INI = (g == 2) ? 0 : 1;

    ksa_gen_if #(.KEY_BYTES(KB)) bus ();

    assign bus.en      = en_v[g];
    assign bus.key     = key_v[g][8*KB-1:0];
    assign bus.rddata  = pipe[g][LAT-1];
    assign rdy_v[g]    = bus.rdy;
    assign wren_v[g]   = bus.wren;
    assign addr_v[g]   = bus.addr;
    assign wrdata_v[g] = bus.wrdata;

    ksa_gen #(.KEY_BYTES(KB), .RD_LAT(LAT), .DO_INIT(INI)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.master)
    );
  end

  // S memories: synchronous read with a 3-deep output pipe tapped per read latency
  always @(posedge clk) begin
    for (int g = 0; g < 3; g++) begin
      if (preload_v[g]) begin
        for (int x = 0; x < 256; x++) mem[g][x] <= 8'(x);
      end else if (wren_v[g]) begin
        mem[g][addr_v[g]] <= wrdata_v[g];
      end
      pipe[g][0] <= mem[g][addr_v[g]];
      pipe[g][1] <= pipe[g][0];
      pipe[g][2] <= pipe[g][1];
    end
  end

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  logic [7:0] exp_s [256];
  int         exp_wa, exp_wd;

  task automatic model(input logic [127:0] key, input int kb);
    int jj;
    logic [7:0] t, kbyte;
    for (int x = 0; x < 256; x++) exp_s[x] = 8'(x);
    jj = 0;
    for (int ii = 0; ii < 256; ii++) begin
      kbyte = key[8*(kb-1-(ii % kb)) +: 8];
      jj = (jj + exp_s[ii] + kbyte) % 256;
      if (ii == 0) begin
        exp_wa = jj;
        exp_wd = exp_s[0];
      end
      t          = exp_s[ii];
      exp_s[ii]  = exp_s[jj];
      exp_s[jj]  = t;
    end
  endtask

  task automatic run(input string name, input int g, input logic [127:0] key, input int exp_cycles,
                     input int wa_req, input int wd_req, input bit use_model_wr,
                     input bit disturb, input bit rst_at_wrj);
    int  n, wr, bad, wa, wd;
    bit  aborted;
    model(key, kb_of(g));
    if (use_model_wr) begin
      wa_req = exp_wa;
      wd_req = exp_wd;
    end
    if (ini_of(g) == 0) begin
      @(negedge clk); preload_v[g] = 1'b1;
      @(negedge clk); preload_v[g] = 1'b0;
    end
    @(negedge clk);
    key_v[g] = key;
    en_v[g]  = 1'b1;
    @(posedge clk); #1;
    en_v[g] = 1'b0;
    chk({name, ".rdy_low"}, 32'(rdy_v[g]), 32'd0);
    n = 0; wr = 0; wa = -1; wd = -1; aborted = 1'b0;
    while (!rdy_v[g] && n < 6000) begin
      if (wren_v[g]) begin
        wr++;
        if (wr == ini_of(g) * 256 + 1) begin
          wa = 32'(addr_v[g]);
          wd = 32'(wrdata_v[g]);
          if (rst_at_wrj) begin
            #2 rst_n = 1'b0;
            #1;
            chk({name, ".rst_wren"}, 32'(wren_v[g]), 32'd0);
            chk({name, ".rst_addr"}, 32'(addr_v[g]), 32'd0);
            chk({name, ".rst_rdy"},  32'(rdy_v[g]),  32'd1);
            #3 rst_n = 1'b1;
            aborted = 1'b1;
            break;
          end
        end
      end
      if (disturb && n == 500) begin
        en_v[g]        = 1'b1;
        key_v[g][31:0] = $urandom;
      end
      if (disturb && n == 501) en_v[g] = 1'b0;
      if (disturb && n == exp_cycles - 2) en_v[g] = 1'b1;
      @(posedge clk); #1;
      n++;
    end
    en_v[g] = 1'b0;
    if (!aborted) begin
      chk({name, ".cycles"}, 32'(n), 32'(exp_cycles));
      if (disturb) begin
        @(posedge clk); #1;
        chk({name, ".en_at_rise"}, 32'(rdy_v[g]), 32'd1);
      end
      chk({name, ".wrj_addr"}, 32'(wa), 32'(wa_req));
      chk({name, ".wrj_data"}, 32'(wd), 32'(wd_req));
      bad = 0;
      for (int x = 0; x < 256; x++) if (mem[g][x] !== exp_s[x]) bad++;
      chk({name, ".s_bad_entries"}, 32'(bad), 32'd0);
    end
  endtask

  typedef struct {
    string        name;
    int           g;
    logic [127:0] key;
    bit           rnd;
    int           cycles;
    int           wa;
    int           wd;
    bit           disturb;
  } vec_t;

  function automatic vec_t mk(input string name, input int g, input logic [127:0] key, input bit rnd,
                              input int cycles, input int wa, input int wd, input bit disturb);
    vec_t v;
    v.name = name; v.g = g; v.key = key; v.rnd = rnd;
    v.cycles = cycles; v.wa = wa; v.wd = wd; v.disturb = disturb;
    return v;
  endfunction

  vec_t vecs [7];

  initial begin
    logic [127:0] k;
    vecs[0] = mk("zero_key",  0, 128'h000000,     1'b0, 1792, 8'h00, 0, 1'b0);
    vecs[1] = mk("key5",      1, 128'h0102030405, 1'b0, 2304, 8'h01, 0, 1'b0);
    vecs[2] = mk("noinit",    2, 128'h1E4600,     1'b0, 2560, 8'h1E, 0, 1'b0);
    vecs[3] = mk("rnd_cfg0",  0, 128'h0,          1'b1, 1792, 0,     0, 1'b0);
    vecs[4] = mk("rnd_cfg1",  1, 128'h0,          1'b1, 2304, 0,     0, 1'b0);
    vecs[5] = mk("rnd_cfg2",  2, 128'h0,          1'b1, 2560, 0,     0, 1'b0);
    vecs[6] = mk("disturbed", 0, 128'h0,          1'b1, 1792, 0,     0, 1'b1);

    rst_n = 1'b0; en_v = '0; preload_v = '0; key_v = '0;
    #23;
    for (int g = 0; g < 3; g++) begin
      chk($sformatf("reset%0d.rdy", g),    32'(rdy_v[g]),    32'd1);
      chk($sformatf("reset%0d.wren", g),   32'(wren_v[g]),   32'd0);
      chk($sformatf("reset%0d.addr", g),   32'(addr_v[g]),   32'd0);
      chk($sformatf("reset%0d.wrdata", g), 32'(wrdata_v[g]), 32'd0);
    end
    @(negedge clk); rst_n = 1'b1;

    for (int v = 0; v < 7; v++) begin
      k = vecs[v].rnd ? {$urandom, $urandom, $urandom, $urandom} : vecs[v].key;
      run(vecs[v].name, vecs[v].g, k, vecs[v].cycles, vecs[v].wa, vecs[v].wd,
          vecs[v].rnd, vecs[v].disturb, 1'b0);
    end

    k = {$urandom, $urandom, $urandom, $urandom};
    run("reset_wrj",   0, k, 1792, 0, 0, 1'b1, 1'b0, 1'b1);
    run("after_reset", 0, k, 1792, 0, 0, 1'b1, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ksa_gen.md
KSA_GEN -- requirements
Module: ksa_gen

Interface
REQ-001 Parameter KEY_BYTES, default 3, key length in bytes, legal range 1..16.
REQ-002 Parameter RD_LAT, default 1, S-memory read latency in cycles (address cycle to data valid), legal range 1..3.
REQ-003 Parameter DO_INIT, default 1; 1 = block writes s[i]=i before the schedule, 0 = caller pre-initialises S.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 en  input  1  start request, honoured only while rdy=1.
REQ-007 rdy  output  1  high = idle and able to accept en.
REQ-008 key  input  8*KEY_BYTES  key; byte 0 = key[8*KEY_BYTES-1 -: 8] (MSB first), byte n = next lower byte.
REQ-009 addr  output  8  S-memory address.
REQ-010 rddata  input  8  S-memory read data.
REQ-011 wrdata  output  8  S-memory write data.
REQ-012 wren  output  1  S-memory write enable, one write per cycle with wren=1.

Function
REQ-013 The block SHALL compute j=(j+s[i]+key[i mod KEY_BYTES]) mod 256 and swap s[i],s[j] for i=0..255, with j=0 at start.
REQ-014 key is sampled into an internal register in the en-accept cycle; later key changes SHALL NOT affect the run.
REQ-015 en accepted at edge k when rdy=1; rdy SHALL be 0 from edge k until the run ends; en while rdy=0 SHALL be ignored.
REQ-016 States: IDLE, INIT_WR, RD_I, WAIT_I, RD_J, WAIT_J, WR_J, WR_I.
REQ-017 IDLE->INIT_WR on accepted en if DO_INIT=1, else IDLE->RD_I.
REQ-018 INIT_WR: addr=i, wrdata=i, wren=1, 256 cycles (i=0..255), then RD_I with i=0, j=0.
REQ-019 RD_I: addr=i, wren=0, one cycle; WAIT_I: RD_LAT cycles, last cycle captures si=rddata and updates j.
REQ-020 RD_J: addr=j, wren=0, one cycle; WAIT_J: RD_LAT cycles, last cycle captures sj=rddata.
REQ-021 WR_J: addr=j, wrdata=si, wren=1; next WR_I: addr=i, wrdata=sj, wren=1.
REQ-022 WR_I with i<255 SHALL increment i and go to RD_I; WR_I with i=255 SHALL go to IDLE and raise rdy at that edge.
REQ-023 Each iteration SHALL take exactly 2*RD_LAT+4 cycles; total run = DO_INIT*256 + 256*(2*RD_LAT+4) cycles.
REQ-024 Key byte index SHALL be a mod-KEY_BYTES counter advancing with i (no divider); it wraps KEY_BYTES-1 -> 0.
REQ-025 i is 8 bits with an explicit last-iteration flag; j and sums SHALL wrap mod 256.
REQ-026 i==j SHALL follow the same sequence (two writes of the same value), without a special case.
REQ-027 wren SHALL be 0 in IDLE, RD_I, WAIT_I, RD_J, WAIT_J.
REQ-028 en asserted in the same cycle rdy rises SHALL NOT be accepted; acceptance requires rdy=1 at the sampling edge.

Reset
REQ-029 rst_n=0 SHALL immediately, without waiting for a clock edge, force state=IDLE, rdy=1, wren=0, addr=0, wrdata=0, i=0, j=0.
REQ-030 Reset mid-run SHALL abort the run with no further writes; S contents are then undefined and a new en restarts from the beginning.

Structure
REQ-031 Package arc4_pkg SHALL hold the state enum typedef ksa_state_t and the constant S_DEPTH=256.
REQ-032 One sub-module, ksa_keysel, SHALL hold the key register, the mod-KEY_BYTES index counter and the byte mux.

Verification
REQ-033 DO_INIT=1, RD_LAT=1, key=24'h000000: final 256-entry S SHALL match a golden RC4 KSA; rdy SHALL return exactly 1792 cycles after en.
REQ-034 KEY_BYTES=5, key=40'h0102030405: first WR_J SHALL be addr=1 with wrdata=0; final S SHALL match golden.
REQ-035 RD_LAT=3, DO_INIT=0, memory preloaded with identity, key=24'h1E4600: final S SHALL match golden; run length SHALL be 2560 cycles.
REQ-036 en pulsed mid-run and key changed mid-run: no restart, result identical to the undisturbed run.
REQ-037 rst_n asserted between clock edges during WR_J: wren and addr SHALL be 0 and rdy 1 before the next edge; a subsequent en SHALL produce a correct full run.
